mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port data memory between two requesters: the CPU load/store path (port 0) and the I/O / DMA loader (port 1). It runs a level-request / single-cycle-ack handshake on each side and sequences one memory access at a time through a fixed-latency memory. It sits between the control-unit-driven datapath and the memory macro. Round-robin fairness applies by default; fixed priority is a compile option.

Parameters:
AW, 16, address width in bits
DW, 16, data width in bits
MEM_LAT, 1, memory read latency in cycles from mem_en_out to valid mem_rdata_in; legal range 1..7

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
req0_in  input  1  CPU request, level
we0_in  input  1  CPU write enable (1 = write)
addr0_in  input  AW  CPU address
wdata0_in  input  DW  CPU write data
ack0_out  output  1  CPU access complete, 1-cycle pulse
req1_in  input  1  I/O-DMA request, level
we1_in  input  1  I/O-DMA write enable
addr1_in  input  AW  I/O-DMA address
wdata1_in  input  DW  I/O-DMA write data
ack1_out  output  1  I/O-DMA access complete, 1-cycle pulse
rdata_out  output  DW  read data, shared by both ports; valid while the matching ack is high
mem_en_out  output  1  memory access strobe
mem_we_out  output  1  memory write enable
mem_addr_out  output  AW  memory address
mem_wdata_out  output  DW  memory write data
mem_rdata_in  input  DW  memory read data
busy_out  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge) puts the FSM in IDLE and clears the round-robin state so that port 0 wins the first tie. All outputs reset to 0. Reset mid-access aborts the access: no ack, and mem_en_out is 0 from the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select a winner and move to ISSUE. On the same edge, register the winner's we/addr/wdata and its index (gsel). Otherwise stay in IDLE.
- Winner selection, round-robin: if exactly one request is high, that port wins. If both are high, the port not served last wins. The last-served index updates on entry to ISSUE.
- ISSUE, exactly 1 cycle:
  - mem_en_out=1.
  - mem_we_out, mem_addr_out and mem_wdata_out come from the captured registers.
  - Load the wait counter with MEM_LAT and move to WAIT.
  - In every other state, mem_en_out=0 and mem_we_out=0. mem_addr_out and mem_wdata_out hold their last values.
- WAIT, MEM_LAT cycles:
  - The counter decrements each cycle.
  - In the last WAIT cycle (counter==1), on a read, capture mem_rdata_in into rdata_out, then move to RESP.
  - On a write, rdata_out is unchanged.
- RESP, exactly 1 cycle: the ack of gsel is 1 (the other ack is 0), then move to IDLE.
- Timing with MEM_LAT=1: request in cycle c0 -> ISSUE c1 -> WAIT c2 -> ack in c3 -> IDLE c4.
  - Access latency is MEM_LAT+2 cycles from request to ack.
  - Peak throughput is one access per MEM_LAT+3 cycles.
- Requester rules:
  - A requester holds req and its operands stable until ack.
  - Operands are captured at grant, so changes after the grant edge have no effect on the access in flight.
  - Dropping req mid-access does not cancel it; the ack still pulses.
  - req still high in the cycle after ack counts as a new request.
- The two acks are never high in the same cycle. No access is ever issued while busy_out=1.
- rdata_out holds the last read value until the next read completes.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: port 0 (CPU) always wins a tie and the round-robin state is removed. Port 1 can starve while req0_in stays high.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x0040; memory returns 0xBEEF at MEM_LAT=1.
  Required: mem_en_out=1 with addr 0x0040 in c1, ack0_out=1 with rdata_out=0xBEEF in c3, busy_out=0 in c4.
- Single write: req1=1, we1=1, addr1=0x0100, wdata1=0x1234.
  Required: mem_en_out=1, mem_we_out=1, mem_addr_out=0x0100, mem_wdata_out=0x1234 for 1 cycle; ack1_out in c3; rdata_out unchanged.
- Contention: req0 and req1 held continuously from reset.
  Required (round-robin): grants alternate 0,1,0,1 with acks 4 cycles apart.
  Required (ARB_FIXED_PRIO_EN): only ack0_out pulses.
- Latency sweep: MEM_LAT=3 read.
  Required: ack 5 cycles after request; data sampled from the cycle 3 after mem_en_out.
- Reset mid-access: assert rst in the WAIT cycle.
  Required: no ack, all outputs 0 in the next cycle; the first tie after reset goes to port 0.
- Operand change after grant: change addr0 to 0x0FFF the cycle after the request.
  Required: memory still sees 0x0040; a single ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sequencing one access at a time into a fixed-latency single-port memory.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); round-robin otherwise.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_in,
  input  logic          we0_in,
  input  logic [AW-1:0] addr0_in,
  input  logic [DW-1:0] wdata0_in,
  output logic          ack0_out,
  input  logic          req1_in,
  input  logic          we1_in,
  input  logic [AW-1:0] addr1_in,
  input  logic [DW-1:0] wdata1_in,
  output logic          ack1_out,
  output logic [DW-1:0] rdata_out,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in,
  output logic          busy_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [2:0] LAT     = 3'(MEM_LAT);

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gsel_q, gsel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;

`ifndef ARB_FIXED_PRIO_EN
  // last_q resets to 1 so that port 0 takes the first tie
  logic          last_q, last_d;
`endif

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win = ~req0_in;
`else
    win = (req0_in && req1_in) ? ~last_q : ~req0_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gsel_d  = gsel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_in || req1_in) begin
          state_d = S_ISSUE;
          gsel_d  = win;
          we_d    = win ? we1_in    : we0_in;
          addr_d  = win ? addr1_in  : addr0_in;
          wdata_d = win ? wdata1_in : wdata0_in;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = win;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (!we_q) begin
            rdata_d = mem_rdata_in;
          end
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gsel_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gsel_q  <= gsel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Captured operands drive the memory bus directly, so address/data hold between accesses
  assign mem_en_out    = (state_q == S_ISSUE);
  assign mem_we_out    = (state_q == S_ISSUE) && we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign rdata_out     = rdata_q;
  assign ack0_out      = (state_q == S_RESP) && !gsel_q;
  assign ack1_out      = (state_q == S_RESP) && gsel_q;
  assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic [15:0] mrd1, mrd3;

  logic        a0_1, a1_1, en_1, we_1, bz_1;
  logic [15:0] rd_1, ad_1, wd_1;
  logic        a0_3, a1_3, en_3, we_3, bz_3;
  logic [15:0] rd_3, ad_3, wd_3;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_in(req0), .we0_in(we0), .addr0_in(addr0), .wdata0_in(wdata0), .ack0_out(a0_1),
    .req1_in(req1), .we1_in(we1), .addr1_in(addr1), .wdata1_in(wdata1), .ack1_out(a1_1),
    .rdata_out(rd_1), .mem_en_out(en_1), .mem_we_out(we_1), .mem_addr_out(ad_1),
    .mem_wdata_out(wd_1), .mem_rdata_in(mrd1), .busy_out(bz_1)
  );

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_in(req0), .we0_in(we0), .addr0_in(addr0), .wdata0_in(wdata0), .ack0_out(a0_3),
    .req1_in(req1), .we1_in(we1), .addr1_in(addr1), .wdata1_in(wdata1), .ack1_out(a1_3),
    .rdata_out(rd_3), .mem_en_out(en_3), .mem_we_out(we_3), .mem_addr_out(ad_3),
    .mem_wdata_out(wd_3), .mem_rdata_in(mrd3), .busy_out(bz_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
    mrd1 = 16'h0; mrd3 = 16'h0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_busy",  {31'd0, bz_1}, 32'd0);
    chk("rst_en",    {31'd0, en_1}, 32'd0);
    chk("rst_acks",  {30'd0, a1_1, a0_1}, 32'd0);
    chk("rst_rdata", {16'd0, rd_1}, 32'd0);
    chk("rst_addr",  {16'd0, ad_1}, 32'd0);

    // single read on port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; mrd1 = 16'hBEEF;
    tick(1);
    chk("rd_c1_en",   {31'd0, en_1}, 32'd1);
    chk("rd_c1_we",   {31'd0, we_1}, 32'd0);
    chk("rd_c1_addr", {16'd0, ad_1}, 32'h0040);
    chk("rd_c1_busy", {31'd0, bz_1}, 32'd1);
    tick(1);
    chk("rd_c2_en",   {31'd0, en_1}, 32'd0);
    chk("rd_c2_ack",  {31'd0, a0_1}, 32'd0);
    tick(1);
    chk("rd_c3_ack0", {31'd0, a0_1}, 32'd1);
    chk("rd_c3_ack1", {31'd0, a1_1}, 32'd0);
    chk("rd_c3_data", {16'd0, rd_1}, 32'hBEEF);
    req0 = 1'b0;
    tick(1);
    chk("rd_c4_busy", {31'd0, bz_1}, 32'd0);
    chk("rd_c4_ack0", {31'd0, a0_1}, 32'd0);
    tick(4);

    // single write on port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'h1234; mrd1 = 16'hDEAD;
    tick(1);
    chk("wr_c1_en",    {31'd0, en_1}, 32'd1);
    chk("wr_c1_we",    {31'd0, we_1}, 32'd1);
    chk("wr_c1_addr",  {16'd0, ad_1}, 32'h0100);
    chk("wr_c1_wdata", {16'd0, wd_1}, 32'h1234);
    tick(1);
    chk("wr_c2_en",    {31'd0, en_1}, 32'd0);
    chk("wr_c2_we",    {31'd0, we_1}, 32'd0);
    chk("wr_c2_hold",  {16'd0, wd_1}, 32'h1234);
    tick(1);
    chk("wr_c3_ack1",  {31'd0, a1_1}, 32'd1);
    chk("wr_c3_ack0",  {31'd0, a0_1}, 32'd0);
    chk("wr_c3_rdata", {16'd0, rd_1}, 32'hBEEF);
    req1 = 1'b0; we1 = 1'b0;
    tick(1);
    chk("wr_c4_busy",  {31'd0, bz_1}, 32'd0);
    tick(4);

    // operands changed after grant must not affect the access in flight
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; mrd1 = 16'h5A5A;
    tick(1);
    chk("op_c1_addr", {16'd0, ad_1}, 32'h0040);
    addr0 = 16'h0FFF;
    tick(1);
    chk("op_c2_addr", {16'd0, ad_1}, 32'h0040);
    chk("op_c2_ack",  {31'd0, a0_1}, 32'd0);
    tick(1);
    chk("op_c3_ack",  {31'd0, a0_1}, 32'd1);
    chk("op_c3_data", {16'd0, rd_1}, 32'h5A5A);
    req0 = 1'b0; addr0 = 16'h0040;
    tick(1);
    chk("op_c4_ack",  {31'd0, a0_1}, 32'd0);
    chk("op_c4_busy", {31'd0, bz_1}, 32'd0);
    tick(6);

    // MEM_LAT=3: data comes from the third cycle after mem_en_out
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; mrd3 = 16'h3000;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      mrd3 = 16'h3000 + 16'(k);
      if (k == 1) chk("lat3_en", {31'd0, en_3}, 32'd1);
      if (k < 5)  chk("lat3_noack", {31'd0, a0_3}, 32'd0);
    end
    chk("lat3_ack",  {31'd0, a0_3}, 32'd1);
    chk("lat3_data", {16'd0, rd_3}, 32'h3004);
    req0 = 1'b0;
    tick(8);

    // contention from reset
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
`ifdef ARB_FIXED_PRIO_EN
      chk("cont_ack0", {31'd0, a0_1}, {31'd0, (k % 4) == 3});
      chk("cont_ack1", {31'd0, a1_1}, 32'd0);
`else
      chk("cont_ack0", {31'd0, a0_1}, {31'd0, (k % 8) == 3});
      chk("cont_ack1", {31'd0, a1_1}, {31'd0, (k % 8) == 7});
`endif
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(8);

    // reset during WAIT aborts the access and restores port 0 tie priority
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; mrd1 = 16'h7777;
    addr1 = 16'h0100;
    tick(2);
    rst = 1'b1;
    req1 = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rmid_ack0",  {31'd0, a0_1}, 32'd0);
    chk("rmid_ack1",  {31'd0, a1_1}, 32'd0);
    chk("rmid_busy",  {31'd0, bz_1}, 32'd0);
    chk("rmid_en",    {31'd0, en_1}, 32'd0);
    chk("rmid_we",    {31'd0, we_1}, 32'd0);
    chk("rmid_addr",  {16'd0, ad_1}, 32'd0);
    chk("rmid_wdata", {16'd0, wd_1}, 32'd0);
    chk("rmid_rdata", {16'd0, rd_1}, 32'd0);
    tick(1);
    chk("rtie_en",   {31'd0, en_1}, 32'd1);
    chk("rtie_addr", {16'd0, ad_1}, 32'h0040);
    tick(2);
    chk("rtie_ack0", {31'd0, a0_1}, 32'd1);
    chk("rtie_ack1", {31'd0, a1_1}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
